// File: rtl/gpio_ctrl_apb_timeout_bridge.sv
// APB bridge from one upstream slave port to NUM_BANKS bank CSR slaves plus an interrupt-status
// CSR. An ACCESS phase that outlasts TIMEOUT_CYCLES is closed with an error response.
module gpio_ctrl_apb_timeout_bridge #(
  parameter int unsigned NUM_BANKS      = 8,
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned INTR_ADDR      = 'h200,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          upstream_paddr,
  input  logic                       upstream_pwrite,
  input  logic                       upstream_psel,
  input  logic                       upstream_penable,
  input  logic [3:0]                 upstream_pstrb,
  input  logic [31:0]                upstream_pwdata,
  output logic [31:0]                upstream_prdata,
  output logic                       upstream_pready,
  output logic                       upstream_pslverr,
  output logic [3:0]                 downstream_paddr,
  output logic                       downstream_pwrite,
  output logic                       downstream_penable,
  output logic [3:0]                 downstream_pstrb,
  output logic [31:0]                downstream_pwdata,
  output logic [NUM_BANKS-1:0]       downstream_bank_psel,
  output logic                       downstream_intr_status_psel,
  input  logic [NUM_BANKS-1:0][31:0] downstream_bank_prdata,
  input  logic [NUM_BANKS-1:0]       downstream_bank_pready,
  input  logic [NUM_BANKS-1:0]       downstream_bank_pslverr,
  input  logic [31:0]                downstream_intr_status_prdata,
  input  logic                       downstream_intr_status_pready,
  input  logic                       downstream_intr_status_pslverr,
  output logic                       bridge_timeout
);

  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [31:0] BANK_SPAN = 32'(NUM_BANKS) << 4;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [BANK_W-1:0]    r_bank_idx;
  logic                 r_tgt_intr;
  logic [3:0]           r_paddr;
  logic                 r_pwrite;
  logic                 r_penable;
  logic [3:0]           r_pstrb;
  logic [31:0]          r_pwdata;
  logic [NUM_BANKS-1:0] r_bank_psel;
  logic                 r_intr_psel;
  logic [31:0]          r_prdata;
  logic                 r_pready;
  logic                 r_pslverr;

  logic [31:0]          w_addr32;
  logic                 w_is_bank;
  logic                 w_is_intr;
  logic                 w_setup;
  logic [BANK_W-1:0]    w_bank_idx;
  logic [NUM_BANKS-1:0] w_bank_onehot;
  logic                 w_sel_pready;
  logic                 w_sel_pslverr;
  logic [31:0]          w_sel_prdata;
  logic                 w_timeout;

  assign w_addr32  = 32'(upstream_paddr);
  assign w_is_bank = (w_addr32 < BANK_SPAN);
  assign w_is_intr = (w_addr32 == INTR_ADDR);
  assign w_setup   = upstream_psel && !upstream_penable;

  generate
    if (NUM_BANKS > 1) begin : g_bank_idx
      assign w_bank_idx = upstream_paddr[BANK_W+3:4];
    end else begin : g_bank_idx_single
      assign w_bank_idx = '0;
    end
  endgenerate

  always_comb begin
    w_bank_onehot = '0;
    w_bank_onehot[w_bank_idx] = 1'b1;
  end

  // Only the captured target's response is looked at; all other slaves are ignored.
  assign w_sel_pready  = r_tgt_intr ? downstream_intr_status_pready  : downstream_bank_pready[r_bank_idx];
  assign w_sel_pslverr = r_tgt_intr ? downstream_intr_status_pslverr : downstream_bank_pslverr[r_bank_idx];
  assign w_sel_prdata  = r_tgt_intr ? downstream_intr_status_prdata  : downstream_bank_prdata[r_bank_idx];

  // Flags the final ACCESS cycle itself, so the pulse leads the dropped psel by one cycle.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == ACCESS) && !w_sel_pready &&
                     (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bank_idx  <= '0;
      r_tgt_intr  <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_penable   <= 1'b0;
      r_pstrb     <= '0;
      r_pwdata    <= '0;
      r_bank_psel <= '0;
      r_intr_psel <= 1'b0;
      r_prdata    <= '0;
      r_pready    <= 1'b0;
      r_pslverr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_setup) begin
            r_paddr    <= upstream_paddr[3:0];
            r_pwrite   <= upstream_pwrite;
            r_pstrb    <= upstream_pstrb;
            r_pwdata   <= upstream_pwdata;
            r_bank_idx <= w_bank_idx;
            r_tgt_intr <= !w_is_bank && w_is_intr;
            if (w_is_bank || w_is_intr) begin
              r_bank_psel <= w_is_bank ? w_bank_onehot : '0;
              r_intr_psel <= !w_is_bank;
              r_penable   <= 1'b0;
              r_state     <= SETUP;
            end else begin
              r_prdata  <= '0;
              r_pslverr <= 1'b1;
              r_pready  <= 1'b1;
              r_state   <= DONE;
            end
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_sel_pready || w_timeout) begin
            r_prdata    <= (w_sel_pready && !r_pwrite) ? w_sel_prdata : 32'h0;
            r_pslverr   <= w_sel_pready ? w_sel_pslverr : 1'b1;
            r_pready    <= 1'b1;
            r_bank_psel <= '0;
            r_intr_psel <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_prdata  <= '0;
          r_pslverr <= 1'b0;
          r_pready  <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign upstream_prdata             = r_prdata;
  assign upstream_pready             = r_pready;
  assign upstream_pslverr            = r_pslverr;
  assign downstream_paddr            = r_paddr;
  assign downstream_pwrite           = r_pwrite;
  assign downstream_penable          = r_penable;
  assign downstream_pstrb            = r_pstrb;
  assign downstream_pwdata           = r_pwdata;
  assign downstream_bank_psel        = r_bank_psel;
  assign downstream_intr_status_psel = r_intr_psel;
  assign bridge_timeout              = w_timeout;

endmodule

// File: tb/tb_gpio_ctrl_apb_timeout_bridge.sv
// Bench for gpio_ctrl_apb_timeout_bridge: directed scenarios plus random transfers scored
// against a transaction-level model of latency, target, read data and error response.
module tb_gpio_ctrl_apb_timeout_bridge;
  localparam int NB = 8;
  localparam int AW = 10;
  localparam int IA = 'h200;
  localparam int TO = 4;
  localparam logic [31:0] SM_BANK = 32'hB000_0000;
  localparam logic [31:0] SM_INTR = 32'h0001_0040;

  typedef struct {
    int lat; logic [31:0] prdata; logic err; int tgt; int multi; logic [3:0] paddr;
    logic req_ok; int tmo_cnt; int tmo_k; int leak; logic done_quiet;
  } obs_t;
  typedef struct { int lat; logic [31:0] prdata; logic err; int tgt; logic [3:0] paddr; int tmo_cnt; int tmo_k; } exp_t;

  int n_checks, n_pass;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0] up_paddr; logic up_pwrite, up_psel, up_penable; logic [3:0] up_pstrb; logic [31:0] up_pwdata;
  logic [31:0] up_prdata; logic up_pready, up_pslverr;
  logic [3:0] dn_paddr; logic dn_pwrite, dn_penable; logic [3:0] dn_pstrb; logic [31:0] dn_pwdata;
  logic [NB-1:0] bank_psel; logic intr_psel, tmo;
  logic [NB-1:0][31:0] bank_prdata; logic [NB-1:0] bank_pready, bank_pslverr;
  logic [31:0] intr_prdata; logic intr_pready, intr_pslverr;

  logic [7:0] b_paddr; logic b_psel, b_penable; logic [31:0] b_prdata; logic b_pready, b_pslverr;
  logic [3:0] b_dn_paddr; logic b_dn_pwrite, b_dn_penable; logic [3:0] b_dn_pstrb; logic [31:0] b_dn_pwdata;
  logic [3:0] b_bank_psel; logic b_intr_psel, b_tmo;
  logic [3:0][31:0] b_bank_prdata;

  gpio_ctrl_apb_timeout_bridge #(.NUM_BANKS(NB), .ADDR_W(AW), .INTR_ADDR(IA), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .rst(rst),
    .upstream_paddr(up_paddr), .upstream_pwrite(up_pwrite), .upstream_psel(up_psel),
    .upstream_penable(up_penable), .upstream_pstrb(up_pstrb), .upstream_pwdata(up_pwdata),
    .upstream_prdata(up_prdata), .upstream_pready(up_pready), .upstream_pslverr(up_pslverr),
    .downstream_paddr(dn_paddr), .downstream_pwrite(dn_pwrite), .downstream_penable(dn_penable),
    .downstream_pstrb(dn_pstrb), .downstream_pwdata(dn_pwdata),
    .downstream_bank_psel(bank_psel), .downstream_intr_status_psel(intr_psel),
    .downstream_bank_prdata(bank_prdata), .downstream_bank_pready(bank_pready),
    .downstream_bank_pslverr(bank_pslverr), .downstream_intr_status_prdata(intr_prdata),
    .downstream_intr_status_pready(intr_pready), .downstream_intr_status_pslverr(intr_pslverr),
    .bridge_timeout(tmo));

  gpio_ctrl_apb_timeout_bridge #(.NUM_BANKS(4), .ADDR_W(8), .INTR_ADDR('h40), .TIMEOUT_CYCLES(TO)) u_dut_small (
    .clk(clk), .rst(rst),
    .upstream_paddr(b_paddr), .upstream_pwrite(1'b0), .upstream_psel(b_psel),
    .upstream_penable(b_penable), .upstream_pstrb(4'h0), .upstream_pwdata(32'h0),
    .upstream_prdata(b_prdata), .upstream_pready(b_pready), .upstream_pslverr(b_pslverr),
    .downstream_paddr(b_dn_paddr), .downstream_pwrite(b_dn_pwrite), .downstream_penable(b_dn_penable),
    .downstream_pstrb(b_dn_pstrb), .downstream_pwdata(b_dn_pwdata),
    .downstream_bank_psel(b_bank_psel), .downstream_intr_status_psel(b_intr_psel),
    .downstream_bank_prdata(b_bank_prdata), .downstream_bank_pready(4'hF),
    .downstream_bank_pslverr(4'h0), .downstream_intr_status_prdata(SM_INTR),
    .downstream_intr_status_pready(1'b1), .downstream_intr_status_pslverr(1'b0),
    .bridge_timeout(b_tmo));

  // Slave responder: the selected slave answers after rsp_waits ACCESS cycles; others emit noise.
  int rsp_waits = 0;
  logic [31:0] rsp_rdata = '0;
  logic rsp_err = 1'b0;
  int acc_cnt = 0;
  logic [NB:0] noise_rdy = '0, noise_err = '0;
  logic [31:0] noise_data = '0;

  always @(posedge clk)
    if (((|bank_psel) || intr_psel) && dn_penable) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;

  always @(negedge clk) begin
    noise_rdy  <= (NB+1)'($urandom);
    noise_err  <= (NB+1)'($urandom);
    noise_data <= $urandom;
  end

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      bank_pready[i]  = bank_psel[i] ? (dn_penable && acc_cnt >= rsp_waits) : noise_rdy[i];
      bank_pslverr[i] = bank_psel[i] ? rsp_err : noise_err[i];
      bank_prdata[i]  = bank_psel[i] ? rsp_rdata : (noise_data ^ 32'(i));
    end
    intr_pready  = intr_psel ? (dn_penable && acc_cnt >= rsp_waits) : noise_rdy[NB];
    intr_pslverr = intr_psel ? rsp_err : noise_err[NB];
    intr_prdata  = intr_psel ? rsp_rdata : ~noise_data;
  end

  function automatic exp_t model(int addr, bit wr, int waits, logic [31:0] rdata, bit err);
    exp_t e;
    e.tgt = (addr < NB*16) ? addr / 16 : ((addr == IA) ? NB : -1);
    e.paddr = 4'(addr % 16);
    e.tmo_cnt = 0; e.tmo_k = -1;
    if (e.tgt < 0) begin e.lat = 1; e.prdata = 0; e.err = 1'b1; end
    else if (waits >= TO) begin e.lat = 2 + TO; e.prdata = 0; e.err = 1'b1; e.tmo_cnt = 1; e.tmo_k = 1 + TO; end
    else begin e.lat = 3 + waits; e.prdata = wr ? 32'h0 : rdata; e.err = err; end
    return e;
  endfunction

  task automatic run_xfer(input int addr, input bit wr, input logic [31:0] wdata, input int waits,
                          input logic [31:0] rdata, input bit err, input bit drop_psel, output obs_t o);
    int k;
    logic [3:0] strb;
    strb = 4'($urandom);
    o.lat = -1; o.prdata = '0; o.err = 1'b0; o.tgt = -1; o.multi = 0; o.paddr = '0;
    o.req_ok = 1'b0; o.tmo_cnt = 0; o.tmo_k = -1; o.leak = 0; o.done_quiet = 1'b0;
    rsp_waits = waits; rsp_rdata = rdata; rsp_err = err;
    @(negedge clk);
    up_paddr = AW'(addr); up_pwrite = wr; up_pwdata = wdata; up_pstrb = strb;
    up_psel = 1'b1; up_penable = 1'b0;
    k = 0;
    while (o.lat < 0 && k < 40) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (k == 1) begin
        if (drop_psel) up_psel = 1'b0;
        else up_penable = 1'b1;
      end
      if ($countones({bank_psel, intr_psel}) > 1) o.multi++;
      if (o.tgt < 0 && ((|bank_psel) || intr_psel)) begin
        o.tgt = NB;
        for (int i = 0; i < NB; i++) if (bank_psel[i]) o.tgt = i;
        o.paddr = dn_paddr;
        o.req_ok = (dn_pwrite == wr) && (dn_pwdata == wdata) && (dn_pstrb == strb) && !dn_penable;
      end
      if (tmo) begin o.tmo_cnt++; o.tmo_k = k; end
      if (up_pready) begin
        o.lat = k; o.prdata = up_prdata; o.err = up_pslverr;
        o.done_quiet = !((|bank_psel) || intr_psel || dn_penable);
      end else if (up_prdata != 0 || up_pslverr) o.leak++;
    end
    up_psel = 1'b0; up_penable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++; if ({up_prdata, up_pready, up_pslverr} !== 34'h0) $display("FAIL reset_upstream got %0h want 0", {up_prdata, up_pready, up_pslverr}); else n_pass++;
    n_checks++; if ({bank_psel, intr_psel} !== '0) $display("FAIL reset_psel got %0h want 0", {bank_psel, intr_psel}); else n_pass++;
    n_checks++; if ({dn_penable, dn_pwrite, dn_paddr, dn_pstrb, dn_pwdata} !== '0) $display("FAIL reset_downstream got %0h want 0", {dn_penable, dn_pwrite, dn_paddr, dn_pstrb, dn_pwdata}); else n_pass++;
    n_checks++; if (tmo !== 1'b0) $display("FAIL reset_timeout got %0b want 0", tmo); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_write_bank();
    obs_t o; exp_t e;
    e = model('h34, 1'b1, 0, 32'h1234_5678, 1'b0);
    run_xfer('h34, 1'b1, 32'hA5A5_0001, 0, 32'h1234_5678, 1'b0, 1'b0, o);
    n_checks++; if (o.tgt !== e.tgt) $display("FAIL wr_bank3_target got %0d want %0d", o.tgt, e.tgt); else n_pass++;
    n_checks++; if (o.multi !== 0) $display("FAIL wr_bank3_onehot got %0d multi-select cycles want 0", o.multi); else n_pass++;
    n_checks++; if (o.paddr !== e.paddr) $display("FAIL wr_bank3_paddr got %0h want %0h", o.paddr, e.paddr); else n_pass++;
    n_checks++; if (o.req_ok !== 1'b1) $display("FAIL wr_bank3_request got %0b want 1", o.req_ok); else n_pass++;
    n_checks++; if (o.lat !== e.lat) $display("FAIL wr_bank3_latency got %0d want %0d", o.lat, e.lat); else n_pass++;
    n_checks++; if ({o.err, o.prdata} !== {e.err, e.prdata}) $display("FAIL wr_bank3_resp got %0h want %0h", {o.err, o.prdata}, {e.err, e.prdata}); else n_pass++;
  endtask

  task automatic test_read_intr();
    obs_t o; exp_t e;
    e = model(IA, 1'b0, 2, 32'h0000_00FF, 1'b0);
    run_xfer(IA, 1'b0, 32'h0, 2, 32'h0000_00FF, 1'b0, 1'b0, o);
    n_checks++; if (o.tgt !== e.tgt) $display("FAIL rd_intr_target got %0d want %0d", o.tgt, e.tgt); else n_pass++;
    n_checks++; if (o.lat !== e.lat) $display("FAIL rd_intr_latency got %0d want %0d", o.lat, e.lat); else n_pass++;
    n_checks++; if (o.prdata !== e.prdata) $display("FAIL rd_intr_prdata got %0h want %0h", o.prdata, e.prdata); else n_pass++;
    n_checks++; if (o.leak !== 0) $display("FAIL rd_intr_early_resp got %0d cycles want 0", o.leak); else n_pass++;
  endtask

  task automatic test_unmapped();
    obs_t o; exp_t e;
    e = model('h180, 1'b0, 0, 32'hDEAD_BEEF, 1'b0);
    run_xfer('h180, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, o);
    n_checks++; if (o.tgt !== e.tgt) $display("FAIL unmapped_target got %0d want %0d", o.tgt, e.tgt); else n_pass++;
    n_checks++; if (o.lat !== e.lat) $display("FAIL unmapped_latency got %0d want %0d", o.lat, e.lat); else n_pass++;
    n_checks++; if ({o.err, o.prdata} !== {e.err, e.prdata}) $display("FAIL unmapped_resp got %0h want %0h", {o.err, o.prdata}, {e.err, e.prdata}); else n_pass++;
  endtask

  task automatic test_timeout();
    obs_t o; exp_t e;
    e = model('h00, 1'b0, 1000, 32'h5555_AAAA, 1'b0);
    run_xfer('h00, 1'b0, 32'h0, 1000, 32'h5555_AAAA, 1'b0, 1'b0, o);
    n_checks++; if (o.tmo_cnt !== e.tmo_cnt) $display("FAIL timeout_pulses got %0d want %0d", o.tmo_cnt, e.tmo_cnt); else n_pass++;
    n_checks++; if (o.tmo_k !== e.tmo_k) $display("FAIL timeout_cycle got %0d want %0d", o.tmo_k, e.tmo_k); else n_pass++;
    n_checks++; if (o.lat !== e.lat) $display("FAIL timeout_latency got %0d want %0d", o.lat, e.lat); else n_pass++;
    n_checks++; if ({o.err, o.prdata} !== {e.err, e.prdata}) $display("FAIL timeout_resp got %0h want %0h", {o.err, o.prdata}, {e.err, e.prdata}); else n_pass++;
    n_checks++; if (o.done_quiet !== 1'b1) $display("FAIL timeout_psel_drop got %0b want 1", o.done_quiet); else n_pass++;
    e = model('h7C, 1'b0, TO - 1, 32'h0BAD_F00D, 1'b0);
    run_xfer('h7C, 1'b0, 32'h0, TO - 1, 32'h0BAD_F00D, 1'b0, 1'b0, o);
    n_checks++; if (o.tmo_cnt !== e.tmo_cnt) $display("FAIL last_cycle_ready_pulses got %0d want %0d", o.tmo_cnt, e.tmo_cnt); else n_pass++;
    n_checks++; if ({o.lat, o.err, o.prdata} !== {e.lat, e.err, e.prdata}) $display("FAIL last_cycle_ready_resp got %0h want %0h", {o.lat, o.err, o.prdata}, {e.lat, e.err, e.prdata}); else n_pass++;
  endtask

  task automatic test_drop_psel();
    obs_t o; exp_t e;
    e = model('h68, 1'b0, 1, 32'hC0DE_0006, 1'b1);
    run_xfer('h68, 1'b0, 32'h0, 1, 32'hC0DE_0006, 1'b1, 1'b1, o);
    n_checks++; if (o.lat !== e.lat) $display("FAIL drop_psel_latency got %0d want %0d", o.lat, e.lat); else n_pass++;
    n_checks++; if ({o.err, o.prdata} !== {e.err, e.prdata}) $display("FAIL drop_psel_resp got %0h want %0h", {o.err, o.prdata}, {e.err, e.prdata}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    run_xfer('h20, 1'b1, 32'h1111_2222, 0, 32'h0, 1'b0, 1'b0, o);
    e = model(IA, 1'b0, 0, 32'h7777_0001, 1'b0);
    run_xfer(IA, 1'b0, 32'h0, 0, 32'h7777_0001, 1'b0, 1'b0, o);
    n_checks++; if (o.lat !== e.lat) $display("FAIL b2b_latency got %0d want %0d", o.lat, e.lat); else n_pass++;
    n_checks++; if (o.prdata !== e.prdata) $display("FAIL b2b_prdata got %0h want %0h", o.prdata, e.prdata); else n_pass++;
  endtask

  task automatic test_done_ignored();
    obs_t o;
    int seen;
    run_xfer('h10, 1'b0, 32'h0, 0, 32'h0, 1'b0, 1'b0, o);
    up_paddr = AW'('h44); up_pwrite = 1'b0; up_psel = 1'b1; up_penable = 1'b0;
    @(negedge clk); up_psel = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (up_pready || (|bank_psel) || intr_psel) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL done_setup_ignored got %0d active cycles want 0", seen); else n_pass++;
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e;
    int seen;
    rsp_waits = 1000;
    @(negedge clk);
    up_paddr = AW'('h57); up_pwrite = 1'b1; up_pwdata = 32'hFEED_0005; up_pstrb = 4'hF;
    up_psel = 1'b1; up_penable = 1'b0;
    @(posedge clk); @(negedge clk); up_penable = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++; if (bank_psel !== 8'h20) $display("FAIL pre_reset_psel got %0h want 20", bank_psel); else n_pass++;
    rst = 1'b1; #1;
    n_checks++; if ({bank_psel, intr_psel, dn_penable, tmo} !== '0) $display("FAIL mid_reset_ctrl got %0h want 0", {bank_psel, intr_psel, dn_penable, tmo}); else n_pass++;
    n_checks++; if ({dn_paddr, dn_pwrite, dn_pstrb, dn_pwdata} !== '0) $display("FAIL mid_reset_data got %0h want 0", {dn_paddr, dn_pwrite, dn_pstrb, dn_pwdata}); else n_pass++;
    @(negedge clk); up_psel = 1'b0; up_penable = 1'b0; rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (up_pready || (|bank_psel) || intr_psel) seen++;
    end
    n_checks++; if (seen !== 0) $display("FAIL post_reset_quiet got %0d active cycles want 0", seen); else n_pass++;
    e = model('h57, 1'b0, 1, 32'h0A0B_0C0D, 1'b0);
    run_xfer('h57, 1'b0, 32'h0, 1, 32'h0A0B_0C0D, 1'b0, 1'b0, o);
    n_checks++; if ({o.lat, o.err, o.prdata} !== {e.lat, e.err, e.prdata}) $display("FAIL post_reset_xfer got %0h want %0h", {o.lat, o.err, o.prdata}, {e.lat, e.err, e.prdata}); else n_pass++;
  endtask

  task automatic test_random();
    obs_t o; exp_t e;
    for (int it = 0; it < 40; it++) begin
      int sel, addr, waits;
      bit wr, err, drop;
      logic [31:0] rdata, wdata;
      sel = int'($urandom_range(0, 9));
      if (sel < 6) addr = int'($urandom_range(0, NB*16 - 1));
      else if (sel < 8) addr = IA;
      else begin
        addr = int'($urandom_range(NB*16, (1 << AW) - 1));
        if (addr == IA) addr = IA + 1;
      end
      wr = 1'($urandom); err = 1'($urandom); drop = ($urandom_range(0, 4) == 0);
      waits = int'($urandom_range(0, TO + 1));
      rdata = $urandom; wdata = $urandom;
      e = model(addr, wr, waits, rdata, err);
      run_xfer(addr, wr, wdata, waits, rdata, err, drop, o);
      n_checks++; if (o.tgt !== e.tgt) $display("FAIL rnd%0d_target addr %0h got %0d want %0d", it, addr, o.tgt, e.tgt); else n_pass++;
      n_checks++; if (o.lat !== e.lat) $display("FAIL rnd%0d_latency addr %0h got %0d want %0d", it, addr, o.lat, e.lat); else n_pass++;
      n_checks++; if ({o.err, o.prdata} !== {e.err, e.prdata}) $display("FAIL rnd%0d_resp addr %0h got %0h want %0h", it, addr, {o.err, o.prdata}, {e.err, e.prdata}); else n_pass++;
      n_checks++; if ({o.tmo_cnt, o.tmo_k} !== {e.tmo_cnt, e.tmo_k}) $display("FAIL rnd%0d_timeout got %0d@%0d want %0d@%0d", it, o.tmo_cnt, o.tmo_k, e.tmo_cnt, e.tmo_k); else n_pass++;
      n_checks++; if ({o.multi, o.leak} !== 64'h0) $display("FAIL rnd%0d_protocol got multi %0d leak %0d want 0 0", it, o.multi, o.leak); else n_pass++;
      if (e.tgt >= 0) begin
        n_checks++; if ({o.paddr, o.req_ok, o.done_quiet} !== {e.paddr, 2'b11}) $display("FAIL rnd%0d_request got %0h want %0h", it, {o.paddr, o.req_ok, o.done_quiet}, {e.paddr, 2'b11}); else n_pass++;
      end
    end
  endtask

  task automatic test_small_cfg();
    int addrs[4];
    addrs = '{'h2C, 'h40, 'h0C, 'h41};
    foreach (addrs[j]) begin
      int a, etgt, elat, otgt, olat, k;
      logic [31:0] edata, odata;
      a = addrs[j];
      etgt = (a < 64) ? a / 16 : ((a == 'h40) ? 4 : -1);
      edata = (etgt < 0) ? 32'h0 : ((etgt == 4) ? SM_INTR : SM_BANK + 32'(etgt));
      elat = (etgt < 0) ? 1 : 3;
      otgt = -1; olat = -1; odata = '0; k = 0;
      @(negedge clk);
      b_paddr = 8'(a); b_psel = 1'b1; b_penable = 1'b0;
      while (olat < 0 && k < 12) begin
        @(posedge clk); k++;
        @(negedge clk);
        if (k == 1) b_penable = 1'b1;
        if (otgt < 0 && b_intr_psel) otgt = 4;
        for (int i = 0; i < 4; i++) if (otgt < 0 && b_bank_psel[i]) otgt = i;
        if (b_pready) begin olat = k; odata = b_prdata; end
      end
      b_psel = 1'b0; b_penable = 1'b0;
      n_checks++; if (otgt !== etgt) $display("FAIL small_%0h_target got %0d want %0d", a, otgt, etgt); else n_pass++;
      n_checks++; if (olat !== elat) $display("FAIL small_%0h_latency got %0d want %0d", a, olat, elat); else n_pass++;
      n_checks++; if (odata !== edata) $display("FAIL small_%0h_prdata got %0h want %0h", a, odata, edata); else n_pass++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1;
    up_paddr = '0; up_pwrite = 1'b0; up_psel = 1'b0; up_penable = 1'b0; up_pstrb = '0; up_pwdata = '0;
    b_paddr = '0; b_psel = 1'b0; b_penable = 1'b0;
    for (int i = 0; i < 4; i++) b_bank_prdata[i] = SM_BANK + 32'(i);
    test_reset();
    test_write_bank();
    test_read_intr();
    test_unmapped();
    test_timeout();
    test_drop_psel();
    test_back_to_back();
    test_done_ignored();
    test_reset_mid();
    test_random();
    test_small_cfg();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
